// File: rtl/ram_rect_writer.sv
// Rectangle fill engine for the 160x120 frame RAM: clips one request to the
// screen, then issues one registered pixel write per granted cycle in row-major order.
module ram_rect_writer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int ADDR_W   = 15
) (
  input  logic                clock,
  input  logic                clear_b,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [X_W-1:0]      req_x,
  input  logic [Y_W-1:0]      req_y,
  input  logic [X_W-1:0]      req_w,
  input  logic [Y_W-1:0]      req_h,
  input  logic [COLOUR_W-1:0] req_colour,
  input  logic                req_full,
  input  logic                ram_grant,
  output logic                ram_wren,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [COLOUR_W-1:0] ram_data,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, CLIP, WRITE, DONE} state_t;

  localparam logic [X_W:0] X_MAX = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H);

  state_t               state, next_state;
  logic [X_W-1:0]       x0, w, x_start, cx;
  logic [Y_W-1:0]       y0, h, cy;
  logic [X_W:0]         x_sum, x_end_c, x_end;
  logic [Y_W:0]         y_sum, y_end_c, y_end;
  logic [COLOUR_W-1:0]  colour;
  logic                 full, empty, col_last, row_last, accept;

  // Held low during reset and for the done-pulse cycle, so a request held
  // across completion is only taken once the engine is genuinely idle.
  assign req_ready = clear_b && (state == IDLE) && !done;
  assign busy      = (state == CLIP) || (state == WRITE);
  assign accept    = req_valid && req_ready;

  // End bounds carry one spare bit so x0+w and y0+h cannot wrap before clipping.
  always_comb begin
    x_sum    = {1'b0, x0} + {1'b0, w};
    y_sum    = {1'b0, y0} + {1'b0, h};
    x_end_c  = (full || x_sum > X_MAX) ? X_MAX : x_sum;
    y_end_c  = (full || y_sum > Y_MAX) ? Y_MAX : y_sum;
    empty    = !full && (w == '0 || h == '0 || {1'b0, x0} >= X_MAX || {1'b0, y0} >= Y_MAX);
    col_last = ({1'b0, cx} + (X_W+1)'(1)) == x_end;
    row_last = ({1'b0, cy} + (Y_W+1)'(1)) == y_end;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = CLIP;
      CLIP:    next_state = empty ? DONE : WRITE;
      WRITE:   if (ram_grant && col_last && row_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) state <= IDLE;
    else          state <= next_state;
  end

  // Write outputs are registered from the counters, so each strobe carries the
  // pixel that the grant of that same edge consumed.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      x0 <= '0; y0 <= '0; w <= '0; h <= '0; colour <= '0; full <= 1'b0;
      x_start <= '0; cx <= '0; cy <= '0; x_end <= '0; y_end <= '0;
      ram_wren <= 1'b0; ram_addr <= '0; ram_data <= '0; done <= 1'b0;
    end else begin
      done     <= (state == DONE);
      ram_wren <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          x0     <= req_x;
          y0     <= req_y;
          w      <= req_w;
          h      <= req_h;
          colour <= req_colour;
          full   <= req_full;
        end
        CLIP: begin
          x_start <= full ? '0 : x0;
          cx      <= full ? '0 : x0;
          cy      <= full ? '0 : y0;
          x_end   <= x_end_c;
          y_end   <= y_end_c;
        end
        WRITE: begin
          ram_wren <= ram_grant;
          ram_addr <= ADDR_W'(cy) * ADDR_W'(SCREEN_W) + ADDR_W'(cx);
          ram_data <= colour;
          if (ram_grant) begin
            if (col_last) begin
              cx <= x_start;
              cy <= cy + Y_W'(1);
            end else begin
              cx <= cx + X_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
